timer_dev: RTL
==============

Name: timer_dev

Overview:
- Memory-mapped countdown timer on the CPU's peripheral bus, directly downstream of the CPU core.
- Consumes the CPU's peripheral address, write data and write enable.
- Returns read data on the CPU's peripheral read-data bus and drives one of the CPU's hardware interrupt inputs (Pr_IP[10]).
- Three word registers: CTRL, PRESET, COUNT. Supports one-shot and auto-reload modes.

Parameters:
- PRESCALE, 1: cycles per COUNT decrement. Only used when TIMER_PRESCALE_EN is defined; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- sel  in  1  bridge decode: this device is addressed
- addr  in  2  word offset, CPU address bits [3:2]
- we  in  1  write strobe, effective only when sel=1
- wdata  in  32  write data
- rdata  out  32  read data (combinational)
- irq  out  1  interrupt request to CPU, registered

Behaviour:
- Register map:
  - Offset 0, CTRL: bit0 EN, bits2:1 MODE, bit3 IM. Bits 31:4 read 0.
  - Offset 1, PRESET: 32-bit, read/write.
  - Offset 2, COUNT: read-only; writes are ignored.
  - Offset 3: reads 0; writes are ignored.
- MODE 0 is one-shot. MODE 1 is auto-reload. MODE 2 and 3 behave as MODE 0.
- rdata is a combinational mux on addr, independent of sel and we.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0, irq=0.
- irq is registered and equals IM & irq_pend.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD. Otherwise stay; COUNT holds.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE and COUNT holds.
    - Else if COUNT>1, COUNT decrements by 1.
    - Else, COUNT<=0 and go to INT.
  - INT, MODE 0: irq_pend<=1, EN<=0, go to IDLE.
  - INT, MODE 1: irq_pend<=1 for exactly one cycle, cleared on the next edge; go to LOAD.
- Latency: from the edge that writes EN=1 to the edge that raises irq is max(PRESET,1)+4 edges.
- MODE 1 period: max(PRESET,1)+2 cycles.
- irq_pend in MODE 0 stays set until any CTRL or PRESET write clears it.
- Simultaneous events:
  - A CPU CTRL write in the same cycle as INT clearing EN: the CPU write wins for CTRL bits. The FSM transition out of INT still occurs.
  - A PRESET write during CNT does not affect the current COUNT; it is used at the next LOAD.
  - CTRL write with EN=0 while in LOAD or CNT: go to IDLE on the next edge.
  - If irq_pend is set by INT on the same edge as a clearing write, the set wins.
- COUNT arithmetic is unsigned 32-bit. COUNT never wraps below 0.
- reset=0 mid-count returns every register and state to its reset value on that edge. No interrupt is generated.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - A 16-bit prescale counter runs while the FSM is in CNT.
  - The CNT decrement/transition is evaluated only on the edge where the prescaler reaches PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler clears on LOAD, on entry to IDLE and on reset.
  - MODE 0 latency becomes PRESCALE*max(PRESET,1)+4.
- Undefined: no prescaler; PRESCALE is ignored; behaviour is as specified above.

Test Plan:
- Reset, then read offsets 0,1,2,3 -> 0,0,0,0; irq=0.
- Write PRESET=3, then CTRL=0x9 -> irq=0 until the 7th edge after the CTRL write edge, then irq=1.
  - COUNT reads 3,2,1,0 on successive cycles.
  - CTRL reads 0x8 once INT has been taken.
  - irq stays 1 until a CTRL write of 0x8, then drops one edge later.
- PRESET=2, CTRL=0xB (MODE 1) -> irq 1-cycle pulses every 4 cycles, 5 pulses observed over 20 cycles; COUNT reload visible as 2.
- PRESET=0, CTRL=0x9 -> irq asserts on the 5th edge after the write (same as PRESET=1).
- Mid-count at COUNT=5 from PRESET=10:
  - CTRL write 0x8 -> COUNT holds 5, no irq.
  - Then CTRL=0x9 -> reload from 10.
  - Then reset=0 for one edge at COUNT=4 -> all registers 0, irq=0.
- Write COUNT=0x1234 and offset 3 -> reads unchanged; write with sel=0 -> ignored.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers with one-shot and auto-reload modes.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_dev #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  logic [1:0]  state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pend;
  logic        pend_auto;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        en_eff;
  logic        tick;

  assign ctrl_wr   = sel & we & (addr == 2'd0);
  assign preset_wr = sel & we & (addr == 2'd1);
  // A CTRL write clearing EN takes effect on the same edge while loading or counting.
  assign en_eff    = ctrl_wr ? wdata[0] : en;

`ifdef TIMER_PRESCALE_EN
  logic [15:0] pre;

  assign tick = (pre == 16'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre <= '0;
    end else if (state == CNT && en_eff) begin
      pre <= tick ? '0 : pre + 16'd1;
    end else begin
      pre <= '0;
    end
  end
`else
  localparam int unsigned unused_prescale = PRESCALE;
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      en        <= 1'b0;
      mode      <= '0;
      im        <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_pend  <= 1'b0;
      pend_auto <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq       <= im & irq_pend;
      pend_auto <= 1'b0;
      if (ctrl_wr) begin
        {im, mode, en} <= wdata[3:0];
      end
      if (preset_wr) begin
        preset <= wdata;
      end
      // Clears come first so that a set from INT on the same edge wins.
      if (ctrl_wr || preset_wr || pend_auto) begin
        irq_pend <= 1'b0;
      end
      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          if (!en_eff) begin
            state <= IDLE;
          end else begin
            count <= preset;
            state <= CNT;
          end
        end
        CNT: begin
          if (!en_eff) begin
            state <= IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= '0;
              state <= INT;
            end
          end
        end
        INT: begin
          irq_pend <= 1'b1;
          if (mode == 2'd1) begin
            pend_auto <= 1'b1;
            state     <= LOAD;
          end else begin
            if (!ctrl_wr) en <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = {28'd0, im, mode, en};
      2'd1:    rdata = preset;
      2'd2:    rdata = count;
      default: rdata = '0;
    endcase
  end

endmodule
